outbox: RTL and testbench
=========================

# outbox

Output-side I/O buffer of the HRM CPU, the counterpart of the inbox. The datapath pushes the signed 12-bit value of register R on each OUTBOX instruction. The block stores these values in order in a circular FIFO. A downstream consumer (testbench checker, display or UART driver) drains them over a valid/ready handshake. Overflow is reported as a sticky error flag so the control unit can halt the program.

## Interface
- LENGTH, 8, FIFO depth in entries; power of two, at least 2
- DATA_W, 12, data width in bits (signed two's complement)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active high
- wOut  in  1  push request from the control unit (OUTBOX instruction)
- data_in  in  DATA_W  signed value of R to push
- clear  in  1  synchronous flush of all entries and of overflow
- full  out  1  FIFO holds LENGTH entries
- count  out  $clog2(LENGTH+1)  number of stored entries, 0..LENGTH
- overflow  out  1  sticky; set when a push is dropped
- o_valid  out  1  o_data holds the oldest entry
- o_ready  in  1  consumer accepts o_data
- o_data  out  DATA_W  oldest entry, signed

## Operation
- Storage: LENGTH x DATA_W register array, write pointer wp and read pointer rp, each $clog2(LENGTH) bits, plus count register.
  - Both pointers wrap from LENGTH-1 to 0 by natural overflow.
- Push accepted iff wOut && !full, using the registered full value of the current cycle.
  - On accept: mem[wp] <= data_in; wp <= wp+1.
- Push when full: data is dropped, no state changes except overflow <= 1.
- Pop occurs iff o_valid && o_ready: rp <= rp+1.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop
- Simultaneous push and pop when full: pop occurs; push is still rejected because full was 1 that cycle, and overflow is set. The control unit must stall on full.
- Simultaneous push and pop when count==1: both occur; count stays 1; o_data moves to the new entry next cycle.
- Push into an empty FIFO: o_valid rises the next cycle. There is no bypass.
- clear has priority over push and pop that cycle.
  - Next cycle: wp=rp=0, count=0, overflow=0.
  - Array contents are left unchanged.
- Derived outputs:
  - full = (count==LENGTH)
  - o_valid = (count!=0)
  - o_data = mem[rp] (first-word fall-through)
- Data passes through unmodified; there is no sign extension or saturation.

## Timing
- Reset (async assert, sync release): wp=0, rp=0, count=0, overflow=0; full=0, o_valid=0.
  - o_data after reset is undefined (array not reset) and must be ignored while o_valid=0.
- Latency from push to o_valid/o_data: 1 cycle.
- Pop to next entry visible on o_data: 1 cycle.
- Throughput: 1 push and 1 pop per cycle.
- o_valid, o_data, full, count and overflow are functions of registers only, with no combinational path from inputs.
- Handshake: once o_valid=1, o_valid and o_data hold until a pop or clear, independent of o_ready.
- Reset asserted mid-transfer discards all entries immediately.

## Structure
- Shared package hrm_pkg holds:
  - DATA_W = 12
  - the signed data type hrm_word_t, shared by inbox, outbox and the datapath
- Natural sub-module: outbox_mem, a LENGTH x DATA_W register file with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stay in outbox.

## Test plan
- Reset, then push 5, -3, 2047, -2048 with o_ready=0.
  - count=4, o_valid=1, o_data=5.
  - Raise o_ready: pops return 5, -3, 2047, -2048 on consecutive cycles, then o_valid=0.
- With o_ready=1, push one value per cycle for 20 cycles (values 0..19).
  - Every value is read in order; count never exceeds 1; full never asserts.
  - Both pointers wrap at least twice.
- Fill 8 entries (1..8), full=1; push 99 with no pop.
  - overflow=1; count stays 8; drain returns 1..8 with no 99.
- Full FIFO (1..8); in one cycle push 42 and pop.
  - 1 is popped; 42 is dropped; overflow=1; count=7.
  - Next cycle push 42 is accepted; drain returns 2..8, 42.
- Three entries stored with overflow=1; pulse clear together with wOut=1 and o_ready=1.
  - Next cycle count=0, o_valid=0, overflow=0, and nothing is pushed.
- Assert rst asynchronously between clock edges while count=5.
  - count=0, o_valid=0, full=0 before the next edge.
  - After release, push 7: o_data=7 one cycle later.

Source files
------------

// File: rtl/hrm_pkg.sv
// Types and constants shared by the HRM CPU datapath, inbox and outbox.
package hrm_pkg;

    // Width of one HRM machine word. Words are signed two's complement.
    localparam int DATA_W = 12;

    // Signed word type carried between the datapath and the I/O buffers.
    typedef logic signed [DATA_W-1:0] hrm_word_t;

    // Extremes of the signed word range.
    localparam hrm_word_t HRM_WORD_MAX = hrm_word_t'(12'sh7FF);
    localparam hrm_word_t HRM_WORD_MIN = hrm_word_t'(12'sh800);

endpackage

// File: rtl/outbox_mem.sv
// Storage array for the outbox FIFO: one synchronous write port and one
// asynchronous read port. The array is not reset, so a word only has
// meaning once it has been written.
module outbox_mem #(
    parameter int LENGTH = 8,
    parameter int DATA_W = hrm_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [$clog2(LENGTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [$clog2(LENGTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]         o_rdata
);

    logic [DATA_W-1:0] r_mem [LENGTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read gives first-word fall-through at the top level.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/outbox.sv
// Outbox: output-side FIFO of the HRM CPU. The control unit pushes the
// value of R on each OUTBOX instruction; a downstream consumer drains the
// entries in order.
//
// Handshake: o_valid/o_data are driven from registers only. Once o_valid
// is 1, o_valid and o_data hold until the entry is popped (o_valid &&
// o_ready at a rising edge) or the FIFO is cleared/reset; they never
// depend on o_ready. A push is accepted only when full was 0 in that
// cycle; a push while full is dropped and sets the sticky overflow flag.
module outbox #(
    parameter int LENGTH = 8,
    parameter int DATA_W = hrm_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wOut,
    input  logic signed [DATA_W-1:0]     data_in,
    input  logic                         clear,
    output logic                         full,
    output logic [$clog2(LENGTH+1)-1:0]  count,
    output logic                         overflow,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic signed [DATA_W-1:0]     o_data
);

    localparam int AW = $clog2(LENGTH);
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(LENGTH);

    // Pointer wrap relies on natural overflow, so depth must be 2^n.
    if (LENGTH < 2 || (LENGTH & (LENGTH - 1)) != 0) begin : g_bad_length
        $error("outbox: LENGTH must be a power of two and at least 2");
    end

    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    // Status derived from the registered count only.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_valid = (r_count != '0);

    // Push uses this cycle's registered full, so a pop in the same cycle
    // does not make room for it.
    assign w_push = wOut && !w_full;
    assign w_pop  = w_valid && o_ready;

    // Clear wins over a push in the same cycle: nothing is written.
    assign w_we = w_push && !clear;

    outbox_mem #(
        .LENGTH (LENGTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wp),
        .i_wdata (data_in),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    // Pointers, occupancy and sticky overflow; clear flushes everything
    // except the array contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (wOut && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign o_valid  = w_valid;
    assign o_data   = w_rdata;

endmodule

// File: tb/tb_outbox.sv
// Directed bench for the outbox FIFO: a vector table for the basic
// push/hold/pop sequence, and hand-written sequences for streaming,
// overflow, full push+pop, clear priority and asynchronous reset.
module tb_outbox;
    import hrm_pkg::*;

    localparam int LENGTH = 8;
    localparam int CW = $clog2(LENGTH + 1);

    logic                 clk;
    logic                 rst;
    logic                 wOut;
    logic signed [DATA_W-1:0] data_in;
    logic                 clear;
    logic                 full;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic                 o_valid;
    logic                 o_ready;
    logic signed [DATA_W-1:0] o_data;

    int total;
    int bad;

    hrm_word_t exp_q[$];

    typedef struct {
        logic w;
        int   din;
        logic clr;
        logic rdy;
        int   e_cnt;
        logic e_vld;
        int   e_dat;
        logic e_full;
        logic e_ovf;
    } vec_t;

    vec_t tbl[9];

    outbox #(
        .LENGTH (LENGTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wOut     (wOut),
        .data_in  (data_in),
        .clear    (clear),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // driver: one push cycle, optionally popping at the same time
    task automatic push(input int v, input logic rdy);
        wOut    = 1'b1;
        data_in = DATA_W'(v);
        o_ready = rdy;
        cycle();
        wOut    = 1'b0;
        o_ready = 1'b0;
    endtask

    // scoreboard: pop n entries, each must match the head of exp_q
    task automatic drain(input int n);
        hrm_word_t e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                chk("drain_queue_empty", 1, 0);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            chk("drain_valid", int'(o_valid), 1);
            chk("drain_data", int'(o_data), int'(e));
            o_ready = 1'b1;
            cycle();
        end
        o_ready = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wOut    = 1'b0;
        data_in = '0;
        clear   = 1'b0;
        o_ready = 1'b0;

        // vectors: {w, din, clr, rdy, count, valid, data, full, ovf}
        tbl[0] = '{1'b1,     5, 1'b0, 1'b0, 1, 1'b1,     5, 1'b0, 1'b0};
        tbl[1] = '{1'b1,    -3, 1'b0, 1'b0, 2, 1'b1,     5, 1'b0, 1'b0};
        tbl[2] = '{1'b1,  2047, 1'b0, 1'b0, 3, 1'b1,     5, 1'b0, 1'b0};
        tbl[3] = '{1'b1, -2048, 1'b0, 1'b0, 4, 1'b1,     5, 1'b0, 1'b0};
        tbl[4] = '{1'b0,     0, 1'b0, 1'b0, 4, 1'b1,     5, 1'b0, 1'b0};
        tbl[5] = '{1'b0,     0, 1'b0, 1'b1, 3, 1'b1,    -3, 1'b0, 1'b0};
        tbl[6] = '{1'b0,     0, 1'b0, 1'b1, 2, 1'b1,  2047, 1'b0, 1'b0};
        tbl[7] = '{1'b0,     0, 1'b0, 1'b1, 1, 1'b1, -2048, 1'b0, 1'b0};
        tbl[8] = '{1'b0,     0, 1'b0, 1'b1, 0, 1'b0,     0, 1'b0, 1'b0};

        // reset state
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // basic push with o_ready=0, hold, then drain
        for (int i = 0; i < 9; i++) begin
            wOut    = tbl[i].w;
            data_in = tbl[i].din[DATA_W-1:0];
            clear   = tbl[i].clr;
            o_ready = tbl[i].rdy;
            cycle();
            chk($sformatf("vec%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("vec%0d_valid", i), int'(o_valid), int'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_data", i), int'(o_data), tbl[i].e_dat);
            end
            chk($sformatf("vec%0d_full", i), int'(full), int'(tbl[i].e_full));
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
        end
        wOut    = 1'b0;
        o_ready = 1'b0;

        // streaming: push and pop every cycle, count stays at 1, pointers wrap
        o_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wOut    = 1'b1;
            data_in = DATA_W'(i);
            cycle();
            chk("stream_data", int'(o_data), i);
            chk("stream_count", int'(count), 1);
            chk("stream_full", int'(full), 0);
        end
        wOut = 1'b0;
        cycle();
        o_ready = 1'b0;
        chk("stream_end_count", int'(count), 0);
        chk("stream_end_valid", int'(o_valid), 0);

        // overflow on push into a full FIFO with no pop
        for (int i = 1; i <= 8; i++) begin
            push(i, 1'b0);
            exp_q.push_back(hrm_word_t'(i));
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 8);
        chk("fill_ovf", int'(overflow), 0);
        push(99, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 8);
        drain(8);
        chk("ovf_drain_valid", int'(o_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // clear to drop the overflow before the next scenario
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr1_ovf", int'(overflow), 0);

        // full FIFO: push and pop in the same cycle
        for (int i = 1; i <= 8; i++) begin
            push(i, 1'b0);
            exp_q.push_back(hrm_word_t'(i));
        end
        chk("fp_head", int'(o_data), 1);
        push(42, 1'b1);
        void'(exp_q.pop_front());
        chk("fp_count", int'(count), 7);
        chk("fp_ovf", int'(overflow), 1);
        chk("fp_full", int'(full), 0);
        chk("fp_data", int'(o_data), 2);
        push(42, 1'b0);
        exp_q.push_back(hrm_word_t'(42));
        chk("fp_refill_count", int'(count), 8);
        drain(8);
        chk("fp_drain_valid", int'(o_valid), 0);

        // clear has priority over push and pop
        push(11, 1'b0);
        push(12, 1'b0);
        push(13, 1'b0);
        chk("cp_count", int'(count), 3);
        chk("cp_ovf", int'(overflow), 1);
        wOut    = 1'b1;
        data_in = DATA_W'(77);
        clear   = 1'b1;
        o_ready = 1'b1;
        cycle();
        wOut    = 1'b0;
        clear   = 1'b0;
        o_ready = 1'b0;
        chk("cp_after_count", int'(count), 0);
        chk("cp_after_valid", int'(o_valid), 0);
        chk("cp_after_ovf", int'(overflow), 0);
        cycle();
        chk("cp_idle_count", int'(count), 0);
        exp_q.delete();

        // asynchronous reset between edges
        for (int i = 1; i <= 5; i++) begin
            push(i, 1'b0);
        end
        chk("ar_count_pre", int'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", int'(count), 0);
        chk("ar_valid", int'(o_valid), 0);
        chk("ar_full", int'(full), 0);
        @(negedge clk);
        rst = 1'b0;
        push(7, 1'b0);
        chk("ar_push_valid", int'(o_valid), 1);
        chk("ar_push_data", int'(o_data), 7);
        chk("ar_push_count", int'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
